// File: rtl/cache_wb_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache responder
// with a FIFO write buffer draining to a single-ported backing memory.
module cache_wb_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 3,
  parameter int WB_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_Data,
  output logic [DATA_W-1:0] rData,
  output logic              hit,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int WA_W  = ADDR_W - 2;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, RESP, WSTALL, MISS, MEMRD} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DRAIN, OWN_READ} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q     [LINES];
  logic [DATA_W-1:0]  line_q    [LINES];
  logic [WA_W-1:0]    wb_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]  wb_data_q [WB_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WA_W-1:0]    waddr;
  logic               addr_lsb_unused;
  logic               is_wr, line_hit, fwd_hit, pop, drain_go, can_enq, enq;
  logic [DATA_W-1:0]  fwd_data;

  assign idx             = Address[INDEX_W+1:2];
  assign tag             = Address[ADDR_W-1:INDEX_W+2];
  assign waddr           = Address[ADDR_W-1:2];
  assign addr_lsb_unused = ^Address[1:0];
  assign is_wr           = write && !read;
  assign line_hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign pop             = (owner_q == OWN_DRAIN) && mem_ready;
  assign drain_go        = (owner_q == OWN_NONE) && (count_q != '0) &&
                           (state_q != MISS) && (state_q != MEMRD);
  assign can_enq         = (count_q < CNT_W'(WB_DEPTH)) || pop;
  assign enq             = ((state_q == IDLE && is_wr) || state_q == WSTALL) && can_enq;

  // Youngest buffered write to the requested word wins, so scan oldest to newest.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot     = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && wb_addr_q[slot] == waddr) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[slot];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read) begin
          if (line_hit || fwd_hit)                    state_d = RESP;
          else if (owner_q == OWN_NONE && !drain_go)  state_d = MEMRD;
          else                                        state_d = MISS;
        end else if (is_wr) begin
          state_d = can_enq ? RESP : WSTALL;
        end
      end
      WSTALL:  if (can_enq) state_d = RESP;
      MISS:    if (owner_q == OWN_NONE) state_d = MEMRD;
      MEMRD:   if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      valid_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      hit       <= 1'b0;
      rData     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      hit     <= (state_d == RESP);
      if (state_q == IDLE && read && (line_hit || fwd_hit))
        rData <= line_hit ? line_q[idx] : fwd_data;
      if (state_q == MEMRD && mem_ready) begin
        rData        <= mem_rdata;
        valid_q[idx] <= 1'b1;
        mem_rd       <= 1'b0;
        owner_q      <= OWN_NONE;
      end
      // Owner transitions below are mutually exclusive by construction.
      if (state_d == MEMRD && state_q != MEMRD) begin
        mem_rd   <= 1'b1;
        mem_addr <= {waddr, 2'b00};
        owner_q  <= OWN_READ;
      end
      if (drain_go) begin
        mem_wr    <= 1'b1;
        mem_addr  <= {wb_addr_q[rd_ptr_q], 2'b00};
        mem_wdata <= wb_data_q[rd_ptr_q];
        owner_q   <= OWN_DRAIN;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        mem_wr   <= 1'b0;
        owner_q  <= OWN_NONE;
      end
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Storage arrays carry no reset; valid bits and buffer count qualify them.
  always_ff @(posedge clock) begin
    if (enq) begin
      wb_addr_q[wr_ptr_q] <= waddr;
      wb_data_q[wr_ptr_q] <= Write_Data;
      if (line_hit) line_q[idx] <= Write_Data;
    end
    if (state_q == MEMRD && mem_ready) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Directed bench for cache_wb_ctrl: read fill/hit, write forwarding, buffer full stall,
// read/drain arbitration, line update/eviction and mid-transaction reset.
module tb_cache_wb_ctrl;
  logic        clock = 1'b0;
  logic        reset, read, write, mem_ready;
  logic [7:0]  Address, mem_addr;
  logic [31:0] Write_Data, rData, mem_wdata, mem_rdata;
  logic        hit, mem_rd, mem_wr;

  int total = 0;
  int bad   = 0;
  int excl_viol = 0;
  logic [7:0]  seen_a[$];
  logic [31:0] seen_d[$];

  cache_wb_ctrl #(.ADDR_W(8), .DATA_W(32), .INDEX_W(3), .WB_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .Address(Address),
    .Write_Data(Write_Data), .rData(rData), .hit(hit), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mem_rd && mem_wr) excl_viol++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // CPU read; serves one memory read with mem_ready on the 3rd cycle mem_rd is seen high.
  task automatic do_read(input logic [7:0] a, input logic [31:0] rd, output int cyc,
                         output int rd_cyc, output logic [31:0] got, output logic [7:0] ra);
    int lat;
    cyc = -1; rd_cyc = 0; got = '0; ra = '0; lat = 0;
    read = 1'b1; Address = a;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (hit) begin cyc = c; got = rData; break; end
      if (mem_rd) begin
        if (rd_cyc == 0) begin rd_cyc = c; ra = mem_addr; end
        lat++;
        if (lat == 3) begin mem_ready = 1'b1; mem_rdata = rd; end
      end
    end
    read = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, output int cyc);
    cyc = -1;
    write = 1'b1; Address = a; Write_Data = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (hit) begin cyc = c; break; end
    end
    write = 1'b0;
    @(negedge clock);
  endtask

  // Acknowledges every issued memory write, recording them in arrival order.
  task automatic drain_all();
    seen_a.delete(); seen_d.delete();
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (mem_wr && !mem_ready) begin
        mem_ready = 1'b1; seen_a.push_back(mem_addr); seen_d.push_back(mem_wdata);
      end else mem_ready = 1'b0;
    end
    @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; read = 1'b0; write = 1'b0; mem_ready = 1'b0;
    Address = '0; Write_Data = '0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0h want=0", hit); end
    total++; if (rData !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", rData); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%0h want=0", mem_rd); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%0h want=0", mem_wr); end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_wdata got=%0h want=0", mem_wdata); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_miss_fill();
    int cyc, rc; logic [31:0] got; logic [7:0] ra;
    do_read(8'hDC, 32'd151, cyc, rc, got, ra);
    total++; if (rc !== 1) begin bad++; $display("FAIL cold_rd_latency got=%0d want=1", rc); end
    total++; if (ra !== 8'hDC) begin bad++; $display("FAIL cold_rd_addr got=%0h want=dc", ra); end
    total++; if (cyc !== 4) begin bad++; $display("FAIL cold_hit_cycle got=%0d want=4", cyc); end
    total++; if (got !== 32'd151) begin bad++; $display("FAIL cold_rdata got=%0d want=151", got); end
    do_read(8'hDC, 32'd0, cyc, rc, got, ra);
    total++; if (cyc !== 1) begin bad++; $display("FAIL rehit_cycle got=%0d want=1", cyc); end
    total++; if (rc !== 0) begin bad++; $display("FAIL rehit_mem_rd got=%0d want=0", rc); end
    total++; if (got !== 32'd151) begin bad++; $display("FAIL rehit_rdata got=%0d want=151", got); end
  endtask

  task automatic test_write_forward();
    int cyc, rc; logic [31:0] got; logic [7:0] ra;
    do_write(8'h5C, 32'd758, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL wr_hit_cycle got=%0d want=1", cyc); end
    total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL wr_drain_issue got=%0h want=1", mem_wr); end
    total++; if (mem_addr !== 8'h5C) begin bad++; $display("FAIL wr_drain_addr got=%0h want=5c", mem_addr); end
    total++; if (mem_wdata !== 32'd758) begin bad++; $display("FAIL wr_drain_data got=%0d want=758", mem_wdata); end
    do_read(8'h5C, 32'd0, cyc, rc, got, ra);
    total++; if (cyc !== 1) begin bad++; $display("FAIL fwd_cycle got=%0d want=1", cyc); end
    total++; if (rc !== 0) begin bad++; $display("FAIL fwd_mem_rd got=%0d want=0", rc); end
    total++; if (got !== 32'd758) begin bad++; $display("FAIL fwd_rdata got=%0d want=758", got); end
    drain_all();
    total++; if (seen_a.size() !== 1) begin bad++; $display("FAIL fwd_drain_count got=%0d want=1", seen_a.size()); end
  endtask

  task automatic test_wb_full();
    int cyc, stall_hits;
    logic [7:0]  wa [5] = '{8'h10, 8'h0C, 8'h9C, 8'h04, 8'hF0};
    logic [31:0] wd [5] = '{32'd921, 32'd67, 32'd631, 32'd403, 32'd246};
    for (int i = 0; i < 4; i++) begin
      do_write(wa[i], wd[i], cyc);
      total++; if (cyc !== 1) begin bad++; $display("FAIL fill_wr%0d_cycle got=%0d want=1", i, cyc); end
    end
    write = 1'b1; Address = wa[4]; Write_Data = wd[4];
    stall_hits = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clock); if (hit) stall_hits++; end
    total++; if (stall_hits !== 0) begin bad++; $display("FAIL full_stall hits=%0d want=0", stall_hits); end
    total++; if (mem_addr !== 8'h10 || mem_wr !== 1'b1) begin bad++; $display("FAIL first_drain addr=%0h wr=%0h want=10/1", mem_addr, mem_wr); end
    total++; if (mem_wdata !== 32'd921) begin bad++; $display("FAIL first_drain_data got=%0d want=921", mem_wdata); end
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL stall_release_hit got=%0h want=1", hit); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL pop_mem_wr got=%0h want=0", mem_wr); end
    write = 1'b0;
    @(negedge clock);
    total++; if (mem_wr !== 1'b1 || mem_addr !== 8'h0C) begin bad++; $display("FAIL second_drain wr=%0h addr=%0h want=1/0c", mem_wr, mem_addr); end
    total++; if (mem_wdata !== 32'd67) begin bad++; $display("FAIL second_drain_data got=%0d want=67", mem_wdata); end
    drain_all();
    total++; if (seen_a.size() !== 4) begin bad++; $display("FAIL rest_count got=%0d want=4", seen_a.size()); end
    for (int i = 0; i < 4 && i < seen_a.size(); i++) begin
      total++;
      if (seen_a[i] !== wa[i+1] || seen_d[i] !== wd[i+1]) begin
        bad++; $display("FAIL order%0d got=%0h:%0d want=%0h:%0d", i, seen_a[i], seen_d[i], wa[i+1], wd[i+1]);
      end
    end
  endtask

  task automatic test_read_during_drain();
    int cyc;
    do_write(8'h30, 32'd11, cyc);
    write = 1'b1; Address = 8'h34; Write_Data = 32'd22;
    @(negedge clock);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rdd_wr2_hit got=%0h want=1", hit); end
    write = 1'b0; read = 1'b1; Address = 8'h28;
    @(negedge clock);
    total++; if (mem_wr !== 1'b1 || mem_addr !== 8'h30) begin bad++; $display("FAIL rdd_drain wr=%0h addr=%0h want=1/30", mem_wr, mem_addr); end
    @(negedge clock);
    @(negedge clock);
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rdd_wait_rd got=%0h want=0", mem_rd); end
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rdd_after_pop rd=%0h wr=%0h want=0/0", mem_rd, mem_wr); end
    @(negedge clock);
    total++; if (mem_rd !== 1'b1 || mem_addr !== 8'h28) begin bad++; $display("FAIL rdd_rd_issue rd=%0h addr=%0h want=1/28", mem_rd, mem_addr); end
    @(negedge clock);
    @(negedge clock);
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rdd_no_drain got=%0h want=0", mem_wr); end
    mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clock);
    mem_ready = 1'b0;
    total++; if (hit !== 1'b1 || rData !== 32'h77) begin bad++; $display("FAIL rdd_hit hit=%0h rdata=%0h want=1/77", hit, rData); end
    read = 1'b0;
    @(negedge clock);
    total++; if (mem_wr !== 1'b1 || mem_addr !== 8'h34 || mem_wdata !== 32'd22) begin
      bad++; $display("FAIL rdd_next_drain wr=%0h addr=%0h data=%0d want=1/34/22", mem_wr, mem_addr, mem_wdata);
    end
    drain_all();
  endtask

  task automatic test_line_update();
    int cyc, rc; logic [31:0] got; logic [7:0] ra;
    do_read(8'hDC, 32'd151, cyc, rc, got, ra);
    total++; if (got !== 32'd151) begin bad++; $display("FAIL upd_pre_rdata got=%0d want=151", got); end
    do_write(8'hDC, 32'd850, cyc);
    drain_all();
    total++; if (seen_a.size() !== 1 || seen_d[0] !== 32'd850) begin bad++; $display("FAIL upd_drain n=%0d data=%0d want=1/850", seen_a.size(), seen_d[0]); end
    do_read(8'hDC, 32'd0, cyc, rc, got, ra);
    total++; if (cyc !== 1 || rc !== 0) begin bad++; $display("FAIL upd_hit cyc=%0d rd=%0d want=1/0", cyc, rc); end
    total++; if (got !== 32'd850) begin bad++; $display("FAIL upd_rdata got=%0d want=850", got); end
    do_read(8'h5C, 32'd758, cyc, rc, got, ra);
    total++; if (rc !== 1 || ra !== 8'h5C) begin bad++; $display("FAIL conflict_miss rd=%0d addr=%0h want=1/5c", rc, ra); end
    total++; if (got !== 32'd758) begin bad++; $display("FAIL conflict_rdata got=%0d want=758", got); end
    do_read(8'hDC, 32'd850, cyc, rc, got, ra);
    total++; if (rc !== 1 || got !== 32'd850) begin bad++; $display("FAIL evicted_refill rd=%0d rdata=%0d want=1/850", rc, got); end
  endtask

  task automatic test_reset_mid();
    int cyc, rc; logic seen_rd; logic [31:0] got; logic [7:0] ra;
    do_write(8'h40, 32'd1, cyc);
    do_write(8'h44, 32'd2, cyc);
    do_write(8'h48, 32'd3, cyc);
    read = 1'b1; Address = 8'h60;
    @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    seen_rd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (mem_rd) begin seen_rd = 1'b1; break; end
    end
    total++; if (seen_rd !== 1'b1) begin bad++; $display("FAIL rst_reach_memrd got=%0h want=1", seen_rd); end
    reset = 1'b0; read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || hit !== 1'b0) begin
      bad++; $display("FAIL rst_outputs rd=%0h wr=%0h hit=%0h want=0/0/0", mem_rd, mem_wr, hit);
    end
    @(negedge clock);
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_buffer_discard wr=%0h want=0", mem_wr); end
    mem_ready = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clock);
    mem_ready = 1'b0;
    total++; if (hit !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL rst_stale_ready hit=%0h rd=%0h want=0/0", hit, mem_rd); end
    do_read(8'hDC, 32'd850, cyc, rc, got, ra);
    total++; if (rc !== 1 || ra !== 8'hDC) begin bad++; $display("FAIL rst_cold_miss rd=%0d addr=%0h want=1/dc", rc, ra); end
    total++; if (got !== 32'd850) begin bad++; $display("FAIL rst_refill_rdata got=%0d want=850", got); end
  endtask

  initial begin
    test_reset();
    test_read_miss_fill();
    test_write_forward();
    test_wb_full();
    test_read_during_drain();
    test_line_update();
    test_reset_mid();
    total++; if (excl_viol !== 0) begin bad++; $display("FAIL rd_wr_exclusive violations=%0d want=0", excl_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
